// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_HOLD  = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_t;

    localparam int          INSTR_W         = 32;
    localparam int          BYTES_PER_INSTR = 4;
    localparam logic [31:0] HALT_WORD       = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory read port, decode handshake and status bundle of the fetch sequencer.
interface fetch_sequencer_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 8
);
    logic                start;
    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [7:0]          mem_rdata;
    logic [INSTR_W-1:0]  instr;
    logic [ADDR_W-1:0]   instr_pc;
    logic                instr_valid;
    logic                instr_ready;
    logic                halted;
    logic                overrun;
    logic [CNT_W-1:0]    fetch_count;

    modport master (
        input  start, mem_rdata, instr_ready,
        output mem_rd, mem_addr, instr, instr_pc, instr_valid, halted, overrun, fetch_count
    );

    modport slave (
        output start, mem_rdata, instr_ready,
        input  mem_rd, mem_addr, instr, instr_pc, instr_valid, halted, overrun, fetch_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch: four reads per word, big-endian assembly,
// valid/ready hand-off to decode, halt on a zero word or end of memory.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(32'd1);
    localparam logic [ADDR_W:0]   PC_STEP  = (ADDR_W+1)'(BYTES_PER_INSTR);
    localparam logic [1:0]        LAST_IDX = 2'(BYTES_PER_INSTR - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(32'd1);

    fetch_state_t        state_r, state_s;
    logic [ADDR_W-1:0]   pc_r, pc_s;
    logic [1:0]          idx_r, idx_s;
    logic                rd_r, rd_s;
    logic                rd_d_r;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [INSTR_W-1:0]  asm_r, asm_s;
    logic [INSTR_W-1:0]  instr_r, instr_s;
    logic [ADDR_W-1:0]   ipc_r, ipc_s;
    logic                valid_r, valid_s;
    logic                halted_r, halted_s;
    logic                overrun_r, overrun_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [ADDR_W:0]     pc_sum_s;

    // Next-state and next-output logic for the fetch FSM
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        idx_s     = idx_r;
        rd_s      = 1'b0;
        addr_s    = addr_r;
        instr_s   = instr_r;
        ipc_s     = ipc_r;
        valid_s   = valid_r;
        halted_s  = halted_r;
        overrun_s = overrun_r;
        cnt_s     = cnt_r;
        pc_sum_s  = {1'b0, pc_r} + PC_STEP;

        // read data lands one cycle after its strobe
        if (rd_d_r) begin
            asm_s = {asm_r[INSTR_W-9:0], bus.mem_rdata};
        end else begin
            asm_s = asm_r;
        end

        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (bus.start) begin
                    state_s   = ST_ISSUE;
                    pc_s      = '0;
                    idx_s     = 2'd0;
                    rd_s      = 1'b1;
                    addr_s    = '0;
                    halted_s  = 1'b0;
                    overrun_s = 1'b0;
                    cnt_s     = '0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_ISSUE: begin
                if (idx_r == LAST_IDX) begin
                    state_s = ST_DRAIN;
                    idx_s   = 2'd0;
                end else begin
                    rd_s   = 1'b1;
                    addr_s = addr_r + ADDR_ONE;
                    idx_s  = idx_r + 2'd1;
                end
            end
            ST_DRAIN: begin
                if (asm_s == HALT_WORD) begin
                    state_s   = ST_HALT;
                    halted_s  = 1'b1;
                    overrun_s = 1'b0;
                end else begin
                    state_s = ST_HOLD;
                    valid_s = 1'b1;
                    instr_s = asm_s;
                    ipc_s   = pc_r;
                end
            end
            ST_HOLD: begin
                if (bus.instr_ready) begin
                    valid_s = 1'b0;
                    cnt_s   = cnt_r + CNT_ONE;
                    // carry out means the last word of memory was just accepted
                    if (pc_sum_s[ADDR_W]) begin
                        state_s   = ST_HALT;
                        halted_s  = 1'b1;
                        overrun_s = 1'b1;
                    end else begin
                        state_s = ST_ISSUE;
                        pc_s    = pc_sum_s[ADDR_W-1:0];
                        addr_s  = pc_sum_s[ADDR_W-1:0];
                        idx_s   = 2'd0;
                        rd_s    = 1'b1;
                    end
                end else begin
                    valid_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r      <= '0;
            idx_r     <= 2'd0;
            rd_r      <= 1'b0;
            rd_d_r    <= 1'b0;
            addr_r    <= '0;
            asm_r     <= '0;
            instr_r   <= '0;
            ipc_r     <= '0;
            valid_r   <= 1'b0;
            halted_r  <= 1'b0;
            overrun_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            pc_r      <= pc_s;
            idx_r     <= idx_s;
            rd_r      <= rd_s;
            rd_d_r    <= rd_r;
            addr_r    <= addr_s;
            asm_r     <= asm_s;
            instr_r   <= instr_s;
            ipc_r     <= ipc_s;
            valid_r   <= valid_s;
            halted_r  <= halted_s;
            overrun_r <= overrun_s;
            cnt_r     <= cnt_s;
        end
    end

    assign bus.mem_rd      = rd_r;
    assign bus.mem_addr    = addr_r;
    assign bus.instr       = instr_r;
    assign bus.instr_pc    = ipc_r;
    assign bus.instr_valid = valid_r;
    assign bus.halted      = halted_r;
    assign bus.overrun     = overrun_r;
    assign bus.fetch_count = cnt_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a 128-byte memory model.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] mem [128];
    logic       watch     = 1'b0;
    logic       wrap_seen = 1'b0;

    fetch_sequencer_if #(.ADDR_W(7), .CNT_W(8)) bus ();

    fetch_sequencer #(.ADDR_W(7), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // synchronous byte memory: data one cycle after the address
    always @(posedge clk) begin
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    // flags any read of address 0 once the run is past its first word
    always @(negedge clk) begin
        if (watch && bus.mem_rd && (bus.mem_addr == 7'd0)) begin
            wrap_seen <= 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mem_clear();
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!bus.instr_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid", 32'(bus.instr_valid), 32'd1);
    endtask

    task automatic wait_halt(input int max);
        int n = 0;
        while (!bus.halted && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("wait_halt", 32'(bus.halted), 32'd1);
    endtask

    initial begin
        mem_clear();
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_count", 32'(bus.fetch_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_mem_rd", 32'(bus.mem_rd), 32'd0);

        // single word then a zero word
        mem[0] = 8'h00; mem[1] = 8'hA0; mem[2] = 8'h80; mem[3] = 8'h93;
        bus.instr_ready = 1'b1;
        pulse_start();
        chk("t1_rd_t1", 32'(bus.mem_rd), 32'd1);
        chk("t1_addr_t1", 32'(bus.mem_addr), 32'd0);
        repeat (3) @(negedge clk);
        chk("t1_rd_t4", 32'(bus.mem_rd), 32'd1);
        chk("t1_addr_t4", 32'(bus.mem_addr), 32'd3);
        @(negedge clk);
        chk("t1_rd_t5", 32'(bus.mem_rd), 32'd0);
        chk("t1_valid_t5", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid_t6", 32'(bus.instr_valid), 32'd1);
        chk("t1_instr", bus.instr, 32'h00A08093);
        chk("t1_pc", 32'(bus.instr_pc), 32'd0);
        @(negedge clk);
        chk("t1_count_t7", 32'(bus.fetch_count), 32'd1);
        chk("t1_rd_t7", 32'(bus.mem_rd), 32'd1);
        chk("t1_addr_t7", 32'(bus.mem_addr), 32'd4);
        chk("t1_valid_t7", 32'(bus.instr_valid), 32'd0);
        repeat (5) @(negedge clk);
        chk("t1_halted", 32'(bus.halted), 32'd1);
        chk("t1_overrun", 32'(bus.overrun), 32'd0);
        chk("t1_count", 32'(bus.fetch_count), 32'd1);
        chk("t1_valid_halt", 32'(bus.instr_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("t1_no_second", 32'(bus.instr_valid), 32'd0);

        // three words with back-pressure on the second, start ignored in HOLD
        mem_clear();
        mem[0] = 8'h11; mem[1]  = 8'h22; mem[2]  = 8'h33; mem[3]  = 8'h44;
        mem[4] = 8'h55; mem[5]  = 8'h66; mem[6]  = 8'h77; mem[7]  = 8'h88;
        mem[8] = 8'h99; mem[9]  = 8'hAA; mem[10] = 8'hBB; mem[11] = 8'hCC;
        bus.instr_ready = 1'b0;
        pulse_start();
        chk("t2_count_clr", 32'(bus.fetch_count), 32'd0);
        chk("t2_halt_clr", 32'(bus.halted), 32'd0);
        repeat (5) @(negedge clk);
        chk("t2_valid0", 32'(bus.instr_valid), 32'd1);
        chk("t2_instr0", bus.instr, 32'h11223344);
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        chk("t2_count1", 32'(bus.fetch_count), 32'd1);
        repeat (5) @(negedge clk);
        chk("t2_valid1", 32'(bus.instr_valid), 32'd1);
        chk("t2_instr1", bus.instr, 32'h55667788);
        chk("t2_pc1", 32'(bus.instr_pc), 32'd4);
        bus.start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            chk("t2_hold_valid", 32'(bus.instr_valid), 32'd1);
            chk("t2_hold_instr", bus.instr, 32'h55667788);
            chk("t2_hold_pc", 32'(bus.instr_pc), 32'd4);
            chk("t2_hold_rd", 32'(bus.mem_rd), 32'd0);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        chk("t2_count2", 32'(bus.fetch_count), 32'd2);
        chk("t2_addr_after", 32'(bus.mem_addr), 32'd8);
        wait_valid(12);
        chk("t2_instr2", bus.instr, 32'h99AABBCC);
        chk("t2_pc2", 32'(bus.instr_pc), 32'd8);
        @(negedge clk);
        wait_halt(12);
        chk("t2_count3", 32'(bus.fetch_count), 32'd3);
        chk("t2_overrun", 32'(bus.overrun), 32'd0);

        // every byte nonzero: run to the end of memory
        for (int i = 0; i < 128; i++) mem[i] = 8'(i + 1);
        pulse_start();
        chk("t3_count_clr", 32'(bus.fetch_count), 32'd0);
        for (int k = 0; k < 32; k++) begin
            wait_valid(12);
            chk("t3_pc", 32'(bus.instr_pc), 32'(k * 4));
            chk("t3_instr", bus.instr,
                {8'(k * 4 + 1), 8'(k * 4 + 2), 8'(k * 4 + 3), 8'(k * 4 + 4)});
            watch = 1'b1;
            @(negedge clk);
        end
        chk("t3_halted", 32'(bus.halted), 32'd1);
        chk("t3_overrun", 32'(bus.overrun), 32'd1);
        chk("t3_count", 32'(bus.fetch_count), 32'd32);
        chk("t3_valid", 32'(bus.instr_valid), 32'd0);
        chk("t3_rd", 32'(bus.mem_rd), 32'd0);
        chk("t3_no_wrap", 32'(wrap_seen), 32'd0);
        watch = 1'b0;

        // asynchronous reset in the third issue cycle
        pulse_start();
        repeat (2) @(negedge clk);
        chk("t4_rd_pre", 32'(bus.mem_rd), 32'd1);
        chk("t4_addr_pre", 32'(bus.mem_addr), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("t4_rd", 32'(bus.mem_rd), 32'd0);
        chk("t4_addr", 32'(bus.mem_addr), 32'd0);
        chk("t4_instr", bus.instr, 32'd0);
        chk("t4_pc", 32'(bus.instr_pc), 32'd0);
        chk("t4_valid", 32'(bus.instr_valid), 32'd0);
        chk("t4_halted", 32'(bus.halted), 32'd0);
        chk("t4_overrun", 32'(bus.overrun), 32'd0);
        chk("t4_count", 32'(bus.fetch_count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        chk("t4_restart_addr", 32'(bus.mem_addr), 32'd0);
        wait_valid(12);
        chk("t4_re_instr", bus.instr, 32'h01020304);
        chk("t4_re_pc", 32'(bus.instr_pc), 32'd0);
        @(negedge clk);
        chk("t4_re_count", 32'(bus.fetch_count), 32'd1);
        chk("t4_re_addr", 32'(bus.mem_addr), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
